// File: rtl/ram_uart_streamer.sv
// ram_uart_streamer: drains a circular byte buffer held in a dual-port RAM
// (1-cycle registered read) and transmits each byte as a UART 8N1 frame.
module ram_uart_streamer #(
  parameter int ADDR_LEN  = 12,
  parameter int CLK_DIV   = 434,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [ADDR_LEN-1:0] wr_ptr,
  output logic [ADDR_LEN-1:0] rd_ptr,
  output logic [ADDR_LEN-1:0] rd_addr,
  input  logic [7:0]          rd_data,
  output logic                busy,
  output logic                uart_tx
);

  localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_LEN-1:0] r_rd_ptr, w_rd_ptr_next;
  logic [7:0]          r_shift, w_shift_next;
  logic [BAUD_W-1:0]   r_baud, w_baud_next;
  logic [2:0]          r_bit_idx, w_bit_idx_next;
  logic                r_tx, w_tx_next;
  logic                w_baud_done;

  // End of the current bit period.
  assign w_baud_done = (r_baud == BAUD_LAST);

  // State and datapath registers; reset drives the line idle immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_rd_ptr  <= '0;
      r_shift   <= '0;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_rd_ptr  <= w_rd_ptr_next;
      r_shift   <= w_shift_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

  // Next-state logic; the baud counter defaults to 0, which both reloads it
  // at the end of a bit and holds it at 0 in IDLE and LOAD.
  always_comb begin
    w_state_next   = r_state;
    w_rd_ptr_next  = r_rd_ptr;
    w_shift_next   = r_shift;
    w_baud_next    = '0;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = r_tx;
    case (r_state)
      S_IDLE: begin
        // The RAM samples rd_addr on this same edge, so rd_data is ready in LOAD.
        if (en && (wr_ptr != r_rd_ptr)) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_shift_next  = rd_data;
        w_rd_ptr_next = r_rd_ptr + 1'b1;
        w_tx_next     = 1'b0;
        w_state_next  = S_START;
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_next   = S_DATA;
          w_tx_next      = r_shift[0];
          w_shift_next   = r_shift >> 1;
          w_bit_idx_next = '0;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next   = S_STOP;
            w_tx_next      = 1'b1;
            w_bit_idx_next = '0;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_tx_next      = r_shift[0];
            w_shift_next   = r_shift >> 1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          if (r_bit_idx == STOP_LAST) begin
            w_state_next   = S_IDLE;
            w_bit_idx_next = '0;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign rd_ptr  = r_rd_ptr;
  assign rd_addr = r_rd_ptr;
  assign busy    = (r_state != S_IDLE);
  assign uart_tx = r_tx;

endmodule

// File: tb/tb_ram_uart_streamer.sv
// tb_ram_uart_streamer: directed + random stimulus against a frame-level
// reference model (buffer contents in address order, fixed frame timing).
module tb_ram_uart_streamer;

  localparam int AW           = 4;
  localparam int DEPTH        = 16;
  localparam int DIV          = 4;
  localparam int SB           = 1;
  localparam int FRAME_LEN    = (9 + SB) * DIV;
  localparam int FRAME_PERIOD = FRAME_LEN + 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          uart_tx;

  logic [7:0] mem [DEPTH];
  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  typedef struct {
    logic [7:0]    b;
    int            start;
    logic [AW-1:0] rp;
  } frame_t;
  frame_t frames[$];

  ram_uart_streamer #(.ADDR_LEN(AW), .CLK_DIV(DIV), .STOP_BITS(SB)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  // Cycle count and the RAM's registered read port.
  always @(posedge clk) begin
    cycle   <= cycle + 1;
    rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: decodes frames, requiring every bit level to hold for DIV cycles.
  initial begin
    logic       act;
    logic       prev_tx;
    logic       lvl;
    int         off;
    int         bitno;
    int         st;
    logic [7:0] byte_v;
    logic [AW-1:0] rp;
    act = 1'b0; prev_tx = 1'b1; lvl = 1'b1; off = 0; st = 0; byte_v = '0; rp = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        act = 1'b0;
      end else if (!act && prev_tx === 1'b1 && uart_tx === 1'b0) begin
        act = 1'b1; off = 0; st = cycle; rp = rd_ptr;
      end
      if (act) begin
        if (off % DIV == 0) lvl = uart_tx;
        else chk("bit_steady", 32'(uart_tx), 32'(lvl));
        if (off % DIV == DIV - 1) begin
          bitno = off / DIV;
          if (bitno == 0) chk("start_bit", 32'(lvl), 32'd0);
          else if (bitno <= 8) byte_v[bitno-1] = lvl;
          else begin
            chk("stop_bit", 32'(lvl), 32'd1);
            if (bitno == 8 + SB) begin
              frames.push_back('{byte_v, st, rp});
              act = 1'b0;
            end
          end
        end
        off++;
      end
      prev_tx = uart_tx;
    end
  end

  task automatic wait_until(input int t);
    while (cycle < t) @(negedge clk);
  endtask

  // Reference model: n bytes from mem[base..] in order, first start 2 cycles
  // after the kick cycle t0, then one frame every FRAME_PERIOD cycles.
  task automatic expect_frames(input int base, input int n, input int t0);
    int budget;
    budget = n * FRAME_PERIOD + 50;
    while (frames.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("frame_count", 32'(frames.size()), 32'(n));
    for (int k = 0; k < n && k < frames.size(); k++) begin
      chk("frame_byte", 32'(frames[k].b), 32'(mem[(base + k) % DEPTH]));
      chk("frame_rd_ptr", 32'(frames[k].rp), 32'((base + k + 1) % DEPTH));
      if (k == 0) chk("first_start", 32'(frames[k].start), 32'(t0 + 2));
      else chk("frame_period", 32'(frames[k].start - frames[k-1].start), 32'(FRAME_PERIOD));
    end
    repeat (3) @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_rd_ptr", 32'(rd_ptr), 32'((base + n) % DEPTH));
    chk("end_no_extra", 32'(frames.size()), 32'(n));
    frames.delete();
  endtask

  initial begin
    int c;
    int s;
    wr_ptr = 4'd5;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);

    // Reset state with a non-empty pointer pending.
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("en0_busy", 32'(busy), 32'd0);
    chk("en0_tx", 32'(uart_tx), 32'd1);
    chk("en0_frames", 32'(frames.size()), 32'd0);
    chk("en0_rd_ptr", 32'(rd_ptr), 32'd0);
    wr_ptr = 4'd0;
    en = 1'b1;
    @(negedge clk);

    // Single byte 0xA5 with cycle-exact checks.
    mem[0] = 8'hA5;
    c = cycle;
    wr_ptr = 4'd1;
    @(negedge clk);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_tx", 32'(uart_tx), 32'd1);
    chk("load_rd_ptr", 32'(rd_ptr), 32'd0);
    @(negedge clk);
    chk("start_tx", 32'(uart_tx), 32'd0);
    chk("start_rd_ptr", 32'(rd_ptr), 32'd1);
    s = cycle;
    wait_until(s + FRAME_LEN - 1);
    chk("stop_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_busy", 32'(busy), 32'd0);
    expect_frames(0, 1, c);

    // Burst: directed extremes followed by random bytes.
    mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h3C;
    mem[4] = 8'($urandom); mem[5] = 8'($urandom);
    c = cycle;
    wr_ptr = 4'd6;
    expect_frames(1, 5, c);

    // Random traffic to bring rd_ptr up to 14, then wrap through 15 -> 0.
    for (int i = 6; i < 14; i++) mem[i] = 8'($urandom);
    c = cycle;
    wr_ptr = 4'd14;
    expect_frames(6, 8, c);
    mem[14] = 8'h11; mem[15] = 8'h22; mem[0] = 8'h33;
    c = cycle;
    wr_ptr = 4'd1;
    expect_frames(14, 3, c);

    // en dropped during data bit 3 of the first of two pending bytes.
    mem[1] = 8'($urandom); mem[2] = 8'($urandom);
    c = cycle;
    wr_ptr = 4'd3;
    wait_until(c + 2 + 4 * DIV + 1);
    chk("en_drop_busy", 32'(busy), 32'd1);
    en = 1'b0;
    expect_frames(1, 1, c);
    repeat (60) @(negedge clk);
    chk("en_held_busy", 32'(busy), 32'd0);
    chk("en_held_frames", 32'(frames.size()), 32'd0);
    chk("en_held_rd_ptr", 32'(rd_ptr), 32'd2);
    c = cycle;
    en = 1'b1;
    expect_frames(2, 1, c);

    // Asynchronous reset between edges during data bit 5.
    mem[3] = 8'($urandom);
    c = cycle;
    wr_ptr = 4'd4;
    wait_until(c + 2 + 6 * DIV + 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_tx", 32'(uart_tx), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    frames.delete();
    c = cycle;
    rstn = 1'b1;
    expect_frames(0, 4, c);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
